// File: rtl/jtframe_lfbuf_ctrl.sv
// Line-frame buffer controller: dumps the collected line to external memory,
// reads the display line back into the screen buffer, then clears the collect buffer.
module jtframe_lfbuf_ctrl #(
    parameter int DW   = 16,
    parameter int VW   = 8,
    parameter int HW   = 9,
    parameter int HLEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lhbl,
    input  logic [VW-1:0]     vrender,
    input  logic              frame,
    input  logic [VW-1:0]     ln_v,
    output logic              line,
    output logic [HW-1:0]     fb_addr,
    input  logic [15:0]       fb_din,
    output logic              fb_clr,
    output logic              fb_done,
    output logic [HW-1:0]     rd_addr,
    output logic [15:0]       fb_dout,
    output logic              scr_we,
    output logic [VW+HW:0]    mem_addr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              ovr
);

    // state    | meaning
    // ST_IDLE  | waiting for the lhbl falling edge
    // ST_WRITE | copy collect buffer to memory {frame,ln_v,c}
    // ST_READ  | copy memory {~frame,vrender,c} to the screen buffer
    // ST_CLEAR | wipe collect buffer, one word per cycle
    // ST_DONE  | single-cycle fb_done pulse
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_CLEAR, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_ADDR, PH_CAPT, PH_WAIT} phase_t;

    localparam logic [HW-1:0] C_LAST = HW'(HLEN - 1);
    localparam logic [15:0]   D_MASK = 16'hffff >> (16 - DW);

    state_t            state, state_nx;
    phase_t            phase, phase_nx;
    logic [HW-1:0]     c, c_nx;
    logic              lhbl_l;
    logic              trig, c_last;
    logic              line_nx, ovr_nx, mem_req_nx, mem_we_nx, scr_we_nx;
    logic [VW+HW:0]    mem_addr_nx;
    logic [15:0]       mem_din_nx, fb_dout_nx;
    logic [HW-1:0]     rd_addr_nx;

    assign trig    = lhbl_l & ~lhbl;
    assign c_last  = c == C_LAST;
    assign fb_addr = c;
    assign fb_clr  = state == ST_CLEAR;
    // A trigger landing on the DONE cycle is an overrun, so the pulse is withheld
    assign fb_done = (state == ST_DONE) & ~trig;

    always_comb begin
        state_nx    = state;
        phase_nx    = phase;
        c_nx        = c;
        line_nx     = line;
        ovr_nx      = ovr;
        mem_req_nx  = mem_req;
        mem_we_nx   = mem_we;
        mem_addr_nx = mem_addr;
        mem_din_nx  = mem_din;
        fb_dout_nx  = fb_dout;
        rd_addr_nx  = rd_addr;
        scr_we_nx   = 1'b0;
        case (state)
            ST_WRITE: begin
                case (phase)
                    PH_ADDR: phase_nx = PH_CAPT;
                    PH_CAPT: begin
                        mem_din_nx  = fb_din & D_MASK;
                        mem_req_nx  = 1'b1;
                        mem_we_nx   = 1'b1;
                        mem_addr_nx = {frame, ln_v, c};
                        phase_nx    = PH_WAIT;
                    end
                    default: if (mem_ack) begin
                        mem_req_nx = 1'b0;
                        mem_we_nx  = 1'b0;
                        phase_nx   = PH_ADDR;
                        if (c_last) begin
                            state_nx = ST_READ;
                            c_nx     = '0;
                        end else begin
                            c_nx = c + 1'b1;
                        end
                    end
                endcase
            end
            ST_READ: begin
                if (phase == PH_WAIT) begin
                    if (mem_ack) begin
                        mem_req_nx = 1'b0;
                        fb_dout_nx = mem_dout & D_MASK;
                        rd_addr_nx = c;
                        scr_we_nx  = 1'b1;
                        phase_nx   = PH_ADDR;
                        if (c_last) begin
                            state_nx = ST_CLEAR;
                            c_nx     = '0;
                        end else begin
                            c_nx = c + 1'b1;
                        end
                    end
                end else begin
                    mem_req_nx  = 1'b1;
                    mem_we_nx   = 1'b0;
                    mem_addr_nx = {~frame, vrender, c};
                    phase_nx    = PH_WAIT;
                end
            end
            ST_CLEAR: begin
                if (c_last) begin
                    state_nx = ST_DONE;
                    c_nx     = '0;
                end else begin
                    c_nx = c + 1'b1;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: ;
        endcase
        // Restart overrides everything, including an ack seen in this same cycle
        if (trig) begin
            state_nx   = ST_WRITE;
            phase_nx   = PH_ADDR;
            c_nx       = '0;
            mem_req_nx = 1'b0;
            mem_we_nx  = 1'b0;
            scr_we_nx  = 1'b0;
            line_nx    = ~line;
            if (state != ST_IDLE) ovr_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= PH_ADDR;
            c        <= '0;
            lhbl_l   <= 1'b0;
            line     <= 1'b0;
            ovr      <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            fb_dout  <= '0;
            rd_addr  <= '0;
            scr_we   <= 1'b0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            c        <= c_nx;
            lhbl_l   <= lhbl;
            line     <= line_nx;
            ovr      <= ovr_nx;
            mem_req  <= mem_req_nx;
            mem_we   <= mem_we_nx;
            mem_addr <= mem_addr_nx;
            mem_din  <= mem_din_nx;
            fb_dout  <= fb_dout_nx;
            rd_addr  <= rd_addr_nx;
            scr_we   <= scr_we_nx;
        end
    end

endmodule

// File: doc/jtframe_lfbuf_ctrl.md
JTFRAME_LFBUF_CTRL -- requirements
Module: jtframe_lfbuf_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, pixel width in bits (max 16).
REQ-002 SHALL have parameter VW, default 8, line-number width.
REQ-003 SHALL have parameter HW, default 9, column-address width.
REQ-004 SHALL have parameter HLEN, default 256, words per line transferred (2..2^HW).
REQ-005 SHALL have port clk input 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-007 SHALL have port lhbl input 1: horizontal blank, active low.
REQ-008 SHALL have port vrender input VW: line to fetch for display.
REQ-009 SHALL have port frame input 1: bank currently being written.
REQ-010 SHALL have port ln_v input VW: line held in the collect buffer.
REQ-011 SHALL have port line output 1: line-buffer half select.
REQ-012 SHALL have port fb_addr output HW: collect-buffer address for read/clear.
REQ-013 SHALL have port fb_din input 16: collect-buffer data, valid 1 cycle after fb_addr.
REQ-014 SHALL have port fb_clr output 1: clear strobe for the collect buffer.
REQ-015 SHALL have port fb_done output 1: one-cycle pulse, line dump finished.
REQ-016 SHALL have port rd_addr output HW: screen-buffer write address.
REQ-017 SHALL have port fb_dout output 16: screen-buffer write data.
REQ-018 SHALL have port scr_we output 1: screen-buffer write enable.
REQ-019 SHALL have port mem_addr output 1+VW+HW: word address {bank,row,col}.
REQ-020 SHALL have port mem_din output 16: write data to external memory.
REQ-021 SHALL have port mem_dout input 16: read data, valid in the mem_ack cycle.
REQ-022 SHALL have ports mem_req and mem_we, each output 1: request and write qualifier.
REQ-023 SHALL have port mem_ack input 1: one-cycle acceptance/completion pulse.
REQ-024 SHALL have port ovr output 1: sticky overrun flag.

Function
REQ-025 SHALL detect the lhbl 1->0 edge from a registered copy of lhbl; this edge is the trigger; on it, line toggles and the FSM enters WRITE with column counter c=0.
REQ-026 SHALL run the FSM states IDLE->WRITE->READ->CLEAR->DONE->IDLE.
REQ-027 WRITE: SHALL drive fb_addr=c, capture fb_din the next cycle into mem_din, then assert mem_req=1, mem_we=1, mem_addr={frame,ln_v,c}.
REQ-028 SHALL hold mem_req, mem_we, mem_addr and mem_din stable until mem_ack; SHALL drop mem_req in the cycle after mem_ack; SHALL keep mem_req low at least one cycle between words.
REQ-029 After the ack for c=HLEN-1 in WRITE, SHALL enter READ with c=0.
REQ-030 READ: SHALL assert mem_req=1, mem_we=0, mem_addr={~frame,vrender,c}.
REQ-031 On mem_ack in READ, SHALL register fb_dout=mem_dout and rd_addr=c, and pulse scr_we for exactly one cycle on the following cycle.
REQ-032 After the ack for c=HLEN-1 in READ, SHALL enter CLEAR with c=0.
REQ-033 CLEAR: SHALL assert fb_clr=1 with fb_addr=c, incrementing c each cycle, for exactly HLEN cycles; SHALL drive fb_clr=0 elsewhere.
REQ-034 DONE: SHALL pulse fb_done for one cycle, then enter IDLE.
REQ-035 Column counter SHALL be HW bits and compare against HLEN-1; no wrap past HLEN-1.
REQ-036 A trigger while not IDLE SHALL abort the current sequence: no fb_done, mem_req deasserted, ovr set to 1, line toggled, and a fresh WRITE started at c=0 the next cycle.
REQ-037 An aborted sequence with mem_req outstanding SHALL ignore a mem_ack arriving in the abort cycle.
REQ-038 mem_req SHALL never be asserted in IDLE, CLEAR or DONE.
REQ-039 scr_we SHALL never be asserted outside READ or its trailing cycle.
REQ-040 The FSM SHALL run on every line, including vertical blank.

Reset
REQ-041 rst=1 SHALL set state IDLE, c=0, and line, fb_clr, fb_done, scr_we, mem_req, mem_we and ovr all 0, with all address and data outputs 0.
REQ-042 rst=1 asserted mid-sequence SHALL abandon the transfer in the same cycle, with no further strobes.
REQ-043 The first trigger after reset release SHALL start normally; the lhbl history register is cleared so a low lhbl during reset is not a trigger.

Verification
REQ-044 HLEN=4, frame=0, ln_v=5, fb_din=addr+0x100, mem_ack 2 cycles after each req, lhbl falls -> writes to {0,5,0..3} with data 0x100..0x103; line=1.
REQ-045 Same run, vrender=7, mem_dout=0xA000+col -> reads {1,7,0..3}, four scr_we pulses with rd_addr 0..3 and fb_dout 0xA000..0xA003.
REQ-046 Same run -> fb_clr high exactly 4 consecutive cycles with fb_addr 0..3, then one fb_done pulse, then IDLE; ovr=0.
REQ-047 mem_ack withheld 50 cycles on the first write -> mem_req and mem_addr stable throughout, no progress, no extra strobes.
REQ-048 Second lhbl fall during READ -> no fb_done, ovr=1, line toggles again, new WRITE starts at c=0.
REQ-049 rst pulsed during WRITE with mem_req=1 -> all outputs 0 the next cycle; a later mem_ack is ignored.
